// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: ALU operations, opcode/funct encodings and the decode bundle.
package cpu_defs;

  localparam int unsigned CORE_XLEN = 32;
  localparam int unsigned ALU_OP_W  = 5;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned STALL_W   = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP   = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_XOR   = 5'd3,
    ALU_OR    = 5'd4,
    ALU_AND   = 5'd5,
    ALU_SLL   = 5'd6,
    ALU_SRL   = 5'd7,
    ALU_SRA   = 5'd8,
    ALU_SLT   = 5'd9,
    ALU_SLTU  = 5'd10,
    ALU_BEQ   = 5'd11,
    ALU_BNE   = 5'd12,
    ALU_BLT   = 5'd13,
    ALU_BGE   = 5'd14,
    ALU_BLTU  = 5'd15,
    ALU_BGEU  = 5'd16,
    ALU_PASSB = 5'd17
  } alu_op_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Everything the execute stage receives with a decoded instruction.
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  alu_src;
    logic                  is_jump;
    logic                  is_jalr;
    logic                  is_branch;
    logic                  pc_src;
    alu_op_t               alu_op;
    logic [2:0]            funct3;
    logic [REG_IDX_W-1:0]  rs1;
    logic [REG_IDX_W-1:0]  rs2;
    logic [REG_IDX_W-1:0]  rd;
    logic [CORE_XLEN-1:0]  imm;
    logic [CORE_XLEN-1:0]  pc;
    logic                  illegal;
  } decode_bundle_t;

  // Register/immediate arithmetic ops; returns 0 for unsupported funct3/funct7 pairs.
  function automatic logic arith_decode(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic is_imm, input logic en_unsigned,
                                        output alu_op_t op);
    logic ok;
    logic plain;
    ok    = 1'b1;
    op    = ALU_NOP;
    plain = is_imm || (f7 == FUNCT7_BASE);
    case (f3)
      FUNCT3_ADD_SUB: begin
        if (!is_imm && f7 == FUNCT7_ALT) op = ALU_SUB;
        else if (plain)                  op = ALU_ADD;
        else                             ok = 1'b0;
      end
      FUNCT3_SLL: begin
        if (f7 == FUNCT7_BASE) op = ALU_SLL;
        else                   ok = 1'b0;
      end
      FUNCT3_SLT: begin
        if (plain) op = ALU_SLT;
        else       ok = 1'b0;
      end
      FUNCT3_SLTU: begin
        if (plain && en_unsigned) op = ALU_SLTU;
        else                      ok = 1'b0;
      end
      FUNCT3_XOR: begin
        if (plain) op = ALU_XOR;
        else       ok = 1'b0;
      end
      FUNCT3_SRL_SRA: begin
        if (f7 == FUNCT7_BASE)     op = ALU_SRL;
        else if (f7 == FUNCT7_ALT) op = ALU_SRA;
        else                       ok = 1'b0;
      end
      FUNCT3_OR: begin
        if (plain) op = ALU_OR;
        else       ok = 1'b0;
      end
      FUNCT3_AND: begin
        if (plain) op = ALU_AND;
        else       ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Load sizes LB/LH/LW/LBU/LHU; stores only LB/LH/LW equivalents.
  function automatic logic mem_size_ok(input logic [2:0] f3, input logic is_load);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = is_load;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_logic.sv
// Combinational instruction decode: control bundle plus source-register usage.
module decode_logic
  import cpu_defs::*;
#(
  parameter int unsigned XLEN        = CORE_XLEN,
  parameter bit          EN_UNSIGNED = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [XLEN-1:0]    pc,
  output decode_bundle_t     bundle,
  output logic               uses_rs1,
  output logic               uses_rs2
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic        legal;
  alu_op_t     arith_op;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Immediate formats, all sign-extended from instr[31].
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  // Opcode decode; unsupported encodings collapse to an illegal bundle with no side effects.
  always_comb begin
    bundle        = '0;
    bundle.alu_op = ALU_NOP;
    bundle.funct3 = funct3;
    bundle.rs1    = instr[19:15];
    bundle.rs2    = instr[24:20];
    bundle.rd     = instr[11:7];
    bundle.pc     = CORE_XLEN'(pc);
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    legal         = 1'b1;
    arith_op      = ALU_NOP;

    case (opcode)
      OPCODE_OP: begin
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
        bundle.reg_write = 1'b1;
        legal            = arith_decode(funct3, funct7, 1'b0, EN_UNSIGNED, arith_op);
        bundle.alu_op    = arith_op;
      end
      OPCODE_OP_IMM: begin
        uses_rs1         = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.imm       = CORE_XLEN'($signed(imm_i));
        legal            = arith_decode(funct3, funct7, 1'b1, EN_UNSIGNED, arith_op);
        bundle.alu_op    = arith_op;
      end
      OPCODE_LOAD: begin
        uses_rs1         = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.mem_read  = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = ALU_ADD;
        bundle.imm       = CORE_XLEN'($signed(imm_i));
        legal            = mem_size_ok(funct3, 1'b1);
      end
      OPCODE_STORE: begin
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
        bundle.mem_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = ALU_ADD;
        bundle.imm       = CORE_XLEN'($signed(imm_s));
        legal            = mem_size_ok(funct3, 1'b0);
      end
      OPCODE_BRANCH: begin
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
        bundle.is_branch = 1'b1;
        bundle.imm       = CORE_XLEN'($signed(imm_b));
        case (funct3)
          FUNCT3_BEQ:  bundle.alu_op = ALU_BEQ;
          FUNCT3_BNE:  bundle.alu_op = ALU_BNE;
          FUNCT3_BLT:  bundle.alu_op = ALU_BLT;
          FUNCT3_BGE:  bundle.alu_op = ALU_BGE;
          FUNCT3_BLTU: begin
            bundle.alu_op = ALU_BLTU;
            legal         = EN_UNSIGNED;
          end
          FUNCT3_BGEU: begin
            bundle.alu_op = ALU_BGEU;
            legal         = EN_UNSIGNED;
          end
          default: legal = 1'b0;
        endcase
      end
      OPCODE_JAL: begin
        bundle.reg_write = 1'b1;
        bundle.is_jump   = 1'b1;
        bundle.pc_src    = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = ALU_ADD;
        bundle.imm       = CORE_XLEN'($signed(imm_j));
      end
      OPCODE_JALR: begin
        uses_rs1         = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.is_jump   = 1'b1;
        bundle.is_jalr   = 1'b1;
        bundle.pc_src    = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = ALU_ADD;
        bundle.imm       = CORE_XLEN'($signed(imm_i));
        legal            = (funct3 == 3'b000);
      end
      OPCODE_LUI: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = ALU_PASSB;
        bundle.imm       = CORE_XLEN'($signed(imm_u));
      end
      OPCODE_AUIPC: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.pc_src    = 1'b1;
        bundle.alu_op    = ALU_ADD;
        bundle.imm       = CORE_XLEN'($signed(imm_u));
      end
      default: legal = 1'b0;
    endcase

    // Illegal instructions keep their raw fields but must not write, access memory or redirect.
    if (!legal) begin
      bundle.reg_write = 1'b0;
      bundle.mem_write = 1'b0;
      bundle.mem_read  = 1'b0;
      bundle.alu_src   = 1'b0;
      bundle.is_jump   = 1'b0;
      bundle.is_jalr   = 1'b0;
      bundle.is_branch = 1'b0;
      bundle.pc_src    = 1'b0;
      bundle.alu_op    = ALU_NOP;
      bundle.imm       = '0;
      bundle.illegal   = 1'b1;
      uses_rs1         = 1'b0;
      uses_rs2         = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready output register, load-use bubble insertion, flush, stall counter.
module decode_stage
  import cpu_defs::*;
#(
  parameter int unsigned XLEN        = CORE_XLEN,
  parameter bit          EN_UNSIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_reg_write,
  output logic                 out_mem_write,
  output logic                 out_mem_read,
  output logic                 out_alu_src,
  output logic                 out_is_jump,
  output logic                 out_is_jalr,
  output logic                 out_is_branch,
  output logic                 out_pc_src,
  output logic [ALU_OP_W-1:0]  out_alu_op,
  output logic [2:0]           out_funct3,
  output logic [REG_IDX_W-1:0] out_rs1,
  output logic [REG_IDX_W-1:0] out_rs2,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_pc,
  output logic                 out_illegal,
  output logic [STALL_W-1:0]   stall_cnt
);

  decode_bundle_t     dec;
  decode_bundle_t     bundle_q;
  logic               valid_q;
  logic               uses_rs1;
  logic               uses_rs2;
  logic               slot_free;
  logic               hazard;
  logic [STALL_W-1:0] stall_q;

  decode_logic #(
    .XLEN        (XLEN),
    .EN_UNSIGNED (EN_UNSIGNED)
  ) u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .bundle   (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // Load-use: the held load's destination is read by the incoming instruction.
  assign slot_free = !valid_q || out_ready;
  assign hazard    = in_valid && valid_q && bundle_q.mem_read && (bundle_q.rd != '0) &&
                     ((uses_rs1 && dec.rs1 == bundle_q.rd) ||
                      (uses_rs2 && dec.rs2 == bundle_q.rd));
  assign in_ready  = flush || (slot_free && !hazard);

  // Output register: flush wins, then accept, then drain (a drain during a hazard is the bubble).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q  <= 1'b1;
      bundle_q <= dec;
    end else if (out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  // Saturating count of cycles spent stalled on a load-use hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (hazard && !flush && stall_q != '1) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign out_valid     = valid_q;
  assign out_reg_write = bundle_q.reg_write;
  assign out_mem_write = bundle_q.mem_write;
  assign out_mem_read  = bundle_q.mem_read;
  assign out_alu_src   = bundle_q.alu_src;
  assign out_is_jump   = bundle_q.is_jump;
  assign out_is_jalr   = bundle_q.is_jalr;
  assign out_is_branch = bundle_q.is_branch;
  assign out_pc_src    = bundle_q.pc_src;
  assign out_alu_op    = bundle_q.alu_op;
  assign out_funct3    = bundle_q.funct3;
  assign out_rs1       = bundle_q.rs1;
  assign out_rs2       = bundle_q.rs2;
  assign out_rd        = bundle_q.rd;
  assign out_imm       = XLEN'($signed(bundle_q.imm));
  assign out_pc        = XLEN'(bundle_q.pc);
  assign out_illegal   = bundle_q.illegal;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic against a reference model.
module tb_decode_stage;
  import cpu_defs::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic out_reg_write, out_mem_write, out_mem_read, out_alu_src;
  logic out_is_jump, out_is_jalr, out_is_branch, out_pc_src, out_illegal;
  logic [4:0] out_alu_op, out_rs1, out_rs2, out_rd;
  logic [2:0] out_funct3;
  logic [XLEN-1:0] out_imm, out_pc;
  logic [31:0] stall_cnt;

  logic nu_in_ready, nu_out_valid, nu_reg_write, nu_mem_write, nu_mem_read, nu_alu_src;
  logic nu_is_jump, nu_is_jalr, nu_is_branch, nu_pc_src, nu_illegal;
  logic [4:0] nu_alu_op, nu_rs1, nu_rs2, nu_rd;
  logic [2:0] nu_funct3;
  logic [XLEN-1:0] nu_imm, nu_pc;
  logic [31:0] nu_stall_cnt;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .EN_UNSIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
    .out_alu_src(out_alu_src), .out_is_jump(out_is_jump), .out_is_jalr(out_is_jalr),
    .out_is_branch(out_is_branch), .out_pc_src(out_pc_src), .out_alu_op(out_alu_op),
    .out_funct3(out_funct3), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  decode_stage #(.XLEN(XLEN), .EN_UNSIGNED(1'b0)) dut_nu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nu_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(nu_out_valid), .out_ready(out_ready),
    .out_reg_write(nu_reg_write), .out_mem_write(nu_mem_write), .out_mem_read(nu_mem_read),
    .out_alu_src(nu_alu_src), .out_is_jump(nu_is_jump), .out_is_jalr(nu_is_jalr),
    .out_is_branch(nu_is_branch), .out_pc_src(nu_pc_src), .out_alu_op(nu_alu_op),
    .out_funct3(nu_funct3), .out_rs1(nu_rs1), .out_rs2(nu_rs2), .out_rd(nu_rd),
    .out_imm(nu_imm), .out_pc(nu_pc), .out_illegal(nu_illegal), .stall_cnt(nu_stall_cnt)
  );

  typedef struct packed {
    logic        rw, mw, mr, asrc, jmp, jalr, br, pcs;
    logic [4:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  int          checks = 0;
  int          passes = 0;
  bit          m_valid;
  exp_t        m_b;
  logic [31:0] m_pc;
  logic [31:0] m_stall;
  logic        last_in_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference decode written from the ISA rules: classify, then fill controls; imm by shifts.
  function automatic void ref_decode(input logic [31:0] ins, input bit en_u,
                                     output exp_t e, output bit u1, output bit u2);
    logic signed [31:0] s;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] iimm, simm, bimm, jimm, uimm;
    bit legal;
    s  = ins;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    iimm = 32'(s >>> 20);
    simm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
    bimm = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    jimm = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    uimm = ins & 32'hFFFF_F000;
    e = '0;
    e.f3 = f3; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    u1 = 0; u2 = 0; legal = 1;
    if (op == 7'h33 || op == 7'h13) begin
      bit imm_form;
      imm_form = (op == 7'h13);
      u1 = 1; u2 = !imm_form; e.rw = 1; e.asrc = imm_form;
      if (imm_form) e.imm = iimm;
      if (f3 == 0 && !imm_form && f7 == 7'h20) e.alu = 5'(ALU_SUB);
      else if (f3 == 5 && f7 == 7'h20) e.alu = 5'(ALU_SRA);
      else if ((f3 == 1 || f3 == 5) && f7 != 0) legal = 0;
      else if (!imm_form && f7 != 0) legal = 0;
      else if (f3 == 3 && !en_u) legal = 0;
      else case (f3)
        0: e.alu = 5'(ALU_ADD);   1: e.alu = 5'(ALU_SLL);
        2: e.alu = 5'(ALU_SLT);   3: e.alu = 5'(ALU_SLTU);
        4: e.alu = 5'(ALU_XOR);   5: e.alu = 5'(ALU_SRL);
        6: e.alu = 5'(ALU_OR);    default: e.alu = 5'(ALU_AND);
      endcase
    end else if (op == 7'h03) begin
      u1 = 1; e.rw = 1; e.mr = 1; e.asrc = 1; e.alu = 5'(ALU_ADD); e.imm = iimm;
      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    end else if (op == 7'h23) begin
      u1 = 1; u2 = 1; e.mw = 1; e.asrc = 1; e.alu = 5'(ALU_ADD); e.imm = simm;
      legal = (f3 <= 2);
    end else if (op == 7'h63) begin
      u1 = 1; u2 = 1; e.br = 1; e.imm = bimm;
      case (f3)
        0: e.alu = 5'(ALU_BEQ);  1: e.alu = 5'(ALU_BNE);
        4: e.alu = 5'(ALU_BLT);  5: e.alu = 5'(ALU_BGE);
        6: begin e.alu = 5'(ALU_BLTU); legal = en_u; end
        7: begin e.alu = 5'(ALU_BGEU); legal = en_u; end
        default: legal = 0;
      endcase
    end else if (op == 7'h6F) begin
      e.rw = 1; e.jmp = 1; e.pcs = 1; e.asrc = 1; e.alu = 5'(ALU_ADD); e.imm = jimm;
    end else if (op == 7'h67) begin
      u1 = 1; e.rw = 1; e.jmp = 1; e.jalr = 1; e.pcs = 1; e.asrc = 1; e.alu = 5'(ALU_ADD);
      e.imm = iimm; legal = (f3 == 0);
    end else if (op == 7'h37) begin
      e.rw = 1; e.asrc = 1; e.alu = 5'(ALU_PASSB); e.imm = uimm;
    end else if (op == 7'h17) begin
      e.rw = 1; e.asrc = 1; e.pcs = 1; e.alu = 5'(ALU_ADD); e.imm = uimm;
    end else begin
      legal = 0;
    end
    if (!legal) begin
      e.rw = 0; e.mw = 0; e.mr = 0; e.asrc = 0; e.jmp = 0; e.jalr = 0; e.br = 0; e.pcs = 0;
      e.alu = 5'(ALU_NOP); e.imm = '0; e.ill = 1; u1 = 0; u2 = 0;
    end
  endfunction

  function automatic logic [13:0] ctrl_obs();
    return {out_reg_write, out_mem_write, out_mem_read, out_alu_src, out_is_jump,
            out_is_jalr, out_is_branch, out_pc_src, out_alu_op, out_illegal};
  endfunction

  function automatic logic [13:0] ctrl_exp(input exp_t e);
    return {e.rw, e.mw, e.mr, e.asrc, e.jmp, e.jalr, e.br, e.pcs, e.alu, e.ill};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_b = '0; m_pc = '0; m_stall = '0;
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("ctrl", 64'(ctrl_obs()), 64'(ctrl_exp(m_b)));
    check("imm", 64'(out_imm), 64'(m_b.imm));
    check("pc", 64'(out_pc), 64'(m_pc));
    check("fields", 64'({out_rs1, out_rs2, out_rd, out_funct3}), 64'({m_b.rs1, m_b.rs2, m_b.rd, m_b.f3}));
  endtask

  // One clock: inputs already applied after a negedge; check in_ready, advance model, check outputs.
  task automatic cycle();
    exp_t d;
    bit u1, u2, hz, rdy;
    #1;
    ref_decode(in_instr, 1'b1, d, u1, u2);
    hz  = in_valid && m_valid && m_b.mr && (m_b.rd != 0) &&
          ((u1 && in_instr[19:15] == m_b.rd) || (u2 && in_instr[24:20] == m_b.rd));
    rdy = flush || ((!m_valid || out_ready) && !hz);
    last_in_ready = in_ready;
    check("in_ready", 64'(in_ready), 64'(rdy));
    if (hz && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (flush) m_valid = 0;
    else if (in_valid && rdy) begin m_valid = 1; m_b = d; m_pc = in_pc; end
    else if (out_ready) m_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return 7'h33;  1: return 7'h13;  2: return 7'h03;  3: return 7'h23;
      4: return 7'h63;  5: return 7'h6F;  6: return 7'h67;  7: return 7'h37;
      8: return 7'h17;  9: return 7'h03;  default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ctrl", 64'(ctrl_obs()), 64'd0);
    check("rst_imm_pc", 64'({out_imm, out_pc}), 64'd0);
    @(negedge clk);

    // addi x1,x0,5
    in_valid = 1; in_instr = 32'h0050_0093; in_pc = 32'h100; out_ready = 1;
    cycle();
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_rd", 64'(out_rd), 64'd1);
    check("addi_imm", 64'(out_imm), 64'd5);
    check("addi_alu", 64'(out_alu_op), 64'(ALU_ADD));
    check("addi_src_rw", 64'({out_alu_src, out_reg_write}), 64'b11);
    in_valid = 0;
    cycle();

    // lw x2,0(x1) then add x3,x2,x1: one bubble
    in_valid = 1; in_instr = 32'h0000_A103; in_pc = 32'h200;
    cycle();
    in_instr = 32'h0011_01B3; in_pc = 32'h204;
    cycle();
    check("lu_in_ready", 64'(last_in_ready), 64'd0);
    check("lu_bubble", 64'(out_valid), 64'd0);
    check("lu_stall", 64'(stall_cnt), 64'd1);
    cycle();
    check("lu_accept", 64'(last_in_ready), 64'd1);
    check("lu_add_rd", 64'({out_valid, out_rd}), 64'({1'b1, 5'd3}));
    in_valid = 0;
    cycle();

    // lw x0 then add x3,x0,x0: no stall on x0
    in_valid = 1; in_instr = 32'h0000_A003; in_pc = 32'h208;
    cycle();
    in_instr = 32'h0000_01B3; in_pc = 32'h20C;
    cycle();
    check("x0_no_stall", 64'(last_in_ready), 64'd1);
    check("x0_stall_cnt", 64'(stall_cnt), 64'd1);

    // beq x0,x0,-4 and lui x5,0x12345
    in_instr = 32'hFE00_0EE3; in_pc = 32'h210;
    cycle();
    check("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
    check("beq_br_rw", 64'({out_is_branch, out_reg_write}), 64'b10);
    in_instr = 32'h1234_52B7; in_pc = 32'h214;
    cycle();
    check("lui_imm", 64'(out_imm), 64'h1234_5000);
    check("lui_alu", 64'(out_alu_op), 64'(ALU_PASSB));
    in_valid = 0;
    cycle();

    // Backpressure for 3 cycles, then flush
    in_valid = 1; in_instr = 32'h0050_0093; in_pc = 32'h300; out_ready = 0;
    cycle();
    in_instr = 32'h1234_52B7; in_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_in_ready", 64'(last_in_ready), 64'd0);
      check("bp_hold", 64'({out_valid, out_imm, out_pc}), 64'({1'b1, 32'd5, 32'h300}));
    end
    flush = 1;
    cycle();
    check("flush_valid", 64'(out_valid), 64'd0);
    flush = 0;

    // Illegal word and unsigned branch under both parameter settings
    out_ready = 1; in_instr = 32'hFFFF_FFFF; in_pc = 32'h400;
    cycle();
    check("ill_flag_ctrl", 64'(ctrl_obs()), 64'd1);
    in_instr = 32'h0020_E463; in_pc = 32'h404;
    cycle();
    check("bltu_en", 64'({out_illegal, out_is_branch, out_alu_op}), 64'({1'b0, 1'b1, 5'(ALU_BLTU)}));
    check("bltu_dis", 64'({nu_out_valid, nu_illegal, nu_is_branch}), 64'b110);
    in_valid = 0;
    cycle();

    // Randomized traffic with small register range to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      logic [6:0] f7;
      int r;
      r  = int'($urandom_range(0, 3));
      f7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'($urandom);
      in_instr  = {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                   5'($urandom_range(0, 3)), pick_op(int'($urandom_range(0, 10)))};
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 0;

    // Asynchronous reset mid-stream
    in_valid = 1; in_instr = 32'h0050_0093; in_pc = 32'h500; out_ready = 0;
    cycle();
    #2 rst = 1;
    #1;
    check("arst_valid", 64'({out_valid, nu_out_valid}), 64'd0);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    check("arst_imm", 64'(out_imm), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 0; in_valid = 0;
    cycle();
    check("arst_in_ready", 64'(last_in_ready), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
